regfile_mp: RTL and testbench

Parametrised multi-port register file, the next generation of the accelerator's 16x32 4R/2W register file. Port counts, width and depth are generic. Each write port has its own enable and an optional accumulate mode (read-modify-write add) for partial-sum updates. Read latency is selectable, with same-cycle write bypass. A built-in clear sequencer zeroes the array one entry per cycle. It sits between the decode/issue stage and the MAC datapath.

---
 rtl/regfile_mp.sv | 64 ++++++
 tb/tb_regfile_mp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with accumulate writes, write bypass, selectable read latency and a clear sequencer
module regfile_mp #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 4,
  parameter int NREAD     = 4,
  parameter int NWRITE    = 2,
  parameter int READ_LAT  = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NREAD*ADDRWIDTH-1:0]  raddr,
  output logic [NREAD*DATAWIDTH-1:0]  rdata,
  input  logic [NWRITE-1:0]           we,
  input  logic [NWRITE-1:0]           wacc,
  input  logic [NWRITE*ADDRWIDTH-1:0] waddr,
  input  logic [NWRITE*DATAWIDTH-1:0] wdata,
  input  logic                        clr_start,
  output logic                        clr_busy,
  output logic                        clr_done
);
  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(DEPTH - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;
  logic [ADDRWIDTH-1:0] ptr;
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DATAWIDTH-1:0] wr_val [DEPTH];
  logic [DATAWIDTH-1:0] rd_val [NREAD];
  assign clr_busy = state == CLEAR;
  always_comb state_nxt = state == IDLE ? (clr_start ? CLEAR : IDLE) : (ptr == LAST ? IDLE : CLEAR);
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wr_val[e] = mem[e];
      for (int p = 0; p < NWRITE; p++)
        if (!clr_busy && we[p] && waddr[p*ADDRWIDTH +: ADDRWIDTH] == ADDRWIDTH'(e))
          wr_val[e] = wacc[p] ? mem[e] + wdata[p*DATAWIDTH +: DATAWIDTH] : wdata[p*DATAWIDTH +: DATAWIDTH];
    end
    for (int r = 0; r < NREAD; r++) rd_val[r] = wr_val[raddr[r*ADDRWIDTH +: ADDRWIDTH]];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= clr_busy ? ptr + 1'b1 : '0;
      clr_done <= clr_busy && ptr == LAST;
      for (int e = 0; e < DEPTH; e++)
        mem[e] <= clr_busy ? (ptr == ADDRWIDTH'(e) ? '0 : mem[e]) : wr_val[e];
    end
  end
  if (READ_LAT == 1) begin : g_reg
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rdata <= '0;
      else for (int r = 0; r < NREAD; r++) rdata[r*DATAWIDTH +: DATAWIDTH] <= rd_val[r];
    end
  end else begin : g_comb
    for (genvar r = 0; r < NREAD; r++) begin : g_port
      assign rdata[r*DATAWIDTH +: DATAWIDTH] = rd_val[r];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a combinational-read and a registered-read instance from one stimulus and checks both against a behavioural model
module tb_regfile_mp;
  localparam int DW = 32, AW = 4, NR = 4, NW = 2, D = 16;
  logic clk = 1'b0, resetn = 1'b0;
  logic [NR*AW-1:0] raddr;
  logic [NW-1:0] we, wacc;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic clr_start;
  logic [NR*DW-1:0] rdata0, rdata1;
  logic busy0, busy1, done0, done1;
  int errors = 0, checks = 0, nbusy = 0, ndone = 0, b0, d0;
  logic [31:0] m [D];
  logic [31:0] old [D];
  logic [31:0] rq [NR];
  logic [31:0] nrq [NR];
  bit busy = 0, done = 0, nd;
  int ptr = 0;

  always #5 clk = ~clk;

  regfile_mp #(.READ_LAT(0)) u0 (.clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata0), .we(we), .wacc(wacc),
    .waddr(waddr), .wdata(wdata), .clr_start(clr_start), .clr_busy(busy0), .clr_done(done0));
  regfile_mp #(.READ_LAT(1)) u1 (.clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata1), .we(we), .wacc(wacc),
    .waddr(waddr), .wdata(wdata), .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // What a read of address a sees this cycle: the committing write if any (last enabled port wins), else storage
  function automatic logic [31:0] exp_rd(int a);
    logic [31:0] v = m[a];
    if (!busy)
      for (int p = 0; p < NW; p++)
        if (we[p] && int'(waddr[p*AW +: AW]) == a)
          v = wacc[p] ? m[a] + wdata[p*DW +: DW] : wdata[p*DW +: DW];
    return v;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < D; i++) m[i] = '0;
      for (int r = 0; r < NR; r++) rq[r] = '0;
      busy = 0; done = 0; ptr = 0;
    end else begin
      for (int r = 0; r < NR; r++) nrq[r] = exp_rd(int'(raddr[r*AW +: AW]));
      nd = busy && ptr == D - 1;
      if (busy) begin
        m[ptr] = '0;
        busy = ptr != D - 1;
        ptr = ptr + 1;
      end else begin
        for (int i = 0; i < D; i++) old[i] = m[i];
        for (int p = 0; p < NW; p++)
          if (we[p]) m[waddr[p*AW +: AW]] = wacc[p] ? old[waddr[p*AW +: AW]] + wdata[p*DW +: DW] : wdata[p*DW +: DW];
        if (clr_start) begin busy = 1; ptr = 0; end
      end
      done = nd;
      for (int r = 0; r < NR; r++) rq[r] = nrq[r];
    end
  end

  always @(negedge clk) begin
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("rd_lat0[%0d]", r), rdata0[r*DW +: DW], exp_rd(int'(raddr[r*AW +: AW])));
      chk($sformatf("rd_lat1[%0d]", r), rdata1[r*DW +: DW], rq[r]);
    end
    chk("busy_lat0", 32'(busy0), 32'(busy));
    chk("busy_lat1", 32'(busy1), 32'(busy));
    chk("done_lat0", 32'(done0), 32'(done));
    chk("done_lat1", 32'(done1), 32'(done));
    if (busy0) nbusy++;
    if (done0) ndone++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int p, int a, logic [31:0] d, bit acc);
    we[p] = 1'b1;
    wacc[p] = acc;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(int r, int a);
    raddr[r*AW +: AW] = AW'(a);
  endtask

  initial begin
    raddr = '0; we = '0; wacc = '0; waddr = '0; wdata = '0; clr_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    chk("reset_busy", 32'(busy0), 0);
    chk("reset_done", 32'(done0), 0);
    for (int i = 0; i < D; i++) begin
      rd(0, i);
      #1 chk("reset_rd", rdata0[31:0], 0);
      step();
    end
    rd(0, 3); wr(0, 3, 32'h11, 0);
    #1 chk("bypass", rdata0[31:0], 32'h11);
    step(); we = '0;
    #1 chk("stored", rdata0[31:0], 32'h11);
    chk("lat1_bypass", rdata1[31:0], 32'h11);
    wr(0, 5, 32'hAA, 0); wr(1, 5, 32'hBB, 0); rd(1, 5);
    step(); we = '0;
    #1 chk("conflict", rdata0[63:32], 32'hBB);
    wr(0, 5, 32'h1, 1); wr(1, 5, 32'h7, 0);
    step(); we = '0; wacc = '0;
    #1 chk("conflict_acc", rdata0[63:32], 32'h7);
    wr(0, 2, 32'hFFFF_FFFF, 0);
    step(); we = '0;
    wr(1, 2, 32'h2, 1); rd(2, 2);
    #1 chk("acc_wrap_bypass", rdata0[95:64], 32'h1);
    step(); we = '0; wacc = '0;
    #1 chk("acc_wrap_stored", rdata0[95:64], 32'h1);
    for (int i = 0; i < D; i += 2) begin
      wr(0, i, 32'hDEAD_0000 + i, 0); wr(1, i + 1, 32'hDEAD_0000 + i + 1, 0);
      step();
    end
    we = '0;
    b0 = nbusy; d0 = ndone;
    clr_start = 1'b1;
    step(); clr_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rd(0, k & 15); rd(1, 15); rd(2, 0);
      if (k == 5) begin wr(0, 15, 32'h1234, 0); wr(1, 0, 32'h5678, 0); end
      #1;
      if (k == 3) chk("partial_clear", rdata0[63:32], 32'hDEAD_000F);
      if (k == 5) chk("dropped_bypass", rdata0[95:64], 32'h0);
      step(); we = '0;
    end
    chk("busy_cycles", nbusy - b0, 16);
    chk("done_pulses", ndone - d0, 1);
    for (int i = 0; i < D; i++) begin
      rd(0, i);
      #1 chk("cleared", rdata0[31:0], 0);
      step();
    end
    clr_start = 1'b1;
    repeat (20) step();
    clr_start = 1'b0;
    for (int n = 0; n < 40 && busy0; n++) step();
    chk("clr_idle", 32'(busy0), 0);
    wr(0, 7, 32'h55, 0); rd(0, 7);
    step(); we = '0;
    #1 chk("lat1_write", rdata1[31:0], 32'h55);
    clr_start = 1'b1;
    step(); clr_start = 1'b0;
    d0 = ndone;
    repeat (7) step();
    resetn = 1'b0;
    #1;
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_rd_lat1", rdata1[31:0], 0);
    chk("rst_rd_lat0", rdata0[31:0], 0);
    chk("rst_done", 32'(done0), 0);
    repeat (3) step();
    resetn = 1'b1;
    repeat (20) step();
    chk("no_done_after_rst", ndone - d0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
